// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C responder with open-drain SDA and no clock stretching
`timescale 1ns/1ps
module i2c_target #(
    parameter int addr_wd     = 7,
    parameter int data_wd     = 8,
    parameter int sync_stages = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               sda_oe,
    input  logic [addr_wd-1:0] own_addr,
    input  logic [data_wd-1:0] tx_data,
    output logic               tx_load,
    output logic [data_wd-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
    localparam logic [3:0] last = 4'(data_wd - 1);
    localparam logic [3:0] full = 4'(data_wd);
    logic [sync_stages-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl_s, sda_s;
    logic scl_rise, scl_fall, start, stop;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [data_wd-1:0] shift, shift_n, shift_in, rx_data_n;
    logic [addr_wd-1:0] addr_q, addr_n;
    logic oe_n, busy_n, rx_valid_n, tx_load_n, rw, rw_n, nack, nack_n;
    assign scl_s    = scl_sync[sync_stages-1];
    assign sda_s    = sda_sync[sync_stages-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;
    assign shift_in = {shift[data_wd-2:0], sda_s};
    // synchronise the bus lines and keep one history flop; idle bus reads high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[sync_stages-2:0], scl_i};
            sda_sync <= {sda_sync[sync_stages-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end
    // state and datapath registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift    <= '0;
            addr_q   <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_load  <= 1'b0;
            rw       <= 1'b0;
            nack     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            addr_q   <= addr_n;
            sda_oe   <= oe_n;
            busy     <= busy_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            tx_load  <= tx_load_n;
            rw       <= rw_n;
            nack     <= nack_n;
        end
    end
    // bus conditions win over bit events; samples on scl rise, drive changes on scl fall
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        addr_n     = addr_q;
        oe_n       = sda_oe;
        busy_n     = busy;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        tx_load_n  = 1'b0;
        rw_n       = rw;
        nack_n     = nack;
        if (start) begin
            state_n = ADDR;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            addr_n  = own_addr;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shift_n = shift_in;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == last) begin
                        rw_n    = sda_s;
                        cnt_n   = '0;
                        state_n = (shift_in[data_wd-1 -: addr_wd] == addr_q) ? ADDR_ACK : IGNORE;
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (cnt == 4'd0) begin
                        oe_n   = 1'b1;
                        busy_n = 1'b1;
                        cnt_n  = 4'd1;
                    end else begin
                        cnt_n     = '0;
                        shift_n   = rw ? tx_data : shift;
                        tx_load_n = rw;
                        oe_n      = rw & ~tx_data[data_wd-1];
                        state_n   = rw ? RD_DATA : WR_DATA;
                    end
                end
                WR_DATA: if (scl_rise && cnt != full) begin
                    shift_n = shift_in;
                    cnt_n   = cnt + 4'd1;
                    if (cnt == last) begin
                        rx_data_n  = shift_in;
                        rx_valid_n = 1'b1;
                    end
                end else if (scl_fall && cnt == full) begin
                    oe_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = WR_ACK;
                end
                WR_ACK: if (scl_fall) begin
                    oe_n    = 1'b0;
                    state_n = WR_DATA;
                end
                RD_DATA: if (scl_fall) begin
                    if (cnt == last) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = RD_ACK;
                    end else begin
                        shift_n = {shift[data_wd-2:0], 1'b1};
                        oe_n    = ~shift[data_wd-2];
                        cnt_n   = cnt + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    nack_n = sda_s;
                    cnt_n  = 4'd1;
                end else if (scl_fall && cnt == 4'd1) begin
                    cnt_n     = '0;
                    shift_n   = nack ? shift : tx_data;
                    tx_load_n = ~nack;
                    oe_n      = ~nack & ~tx_data[data_wd-1];
                    state_n   = nack ? IGNORE : RD_DATA;
                end
                IGNORE: oe_n = 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: transaction-level controller model driving i2c_target with a per-cycle checker
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 8;
    logic clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic [6:0] own_addr = 7'h42;
    logic [7:0] tx_data = 8'h00;
    logic sda_oe, tx_load, rx_valid, busy, sda_bus;
    logic [7:0] rx_data;
    int total = 0, bad = 0, n_pop = 0, n_load = 0, m_load = 0;
    logic chk_oe = 1'b0, exp_oe = 1'b0, quiet = 1'b0, m_hit = 1'b0;
    logic lreq = 1'b0;
    logic [31:0] lact, lexp;
    string lname;
    logic [7:0] exp_rx[$];
    logic [7:0] got;
    logic oe_now;
    assign sda_bus = sda_m & ~sda_oe;
    i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .own_addr(own_addr), .tx_data(tx_data), .tx_load(tx_load),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
    );
    always #5 clk = ~clk;
    // single compare process: bus-level SDA expectations, write-byte scoreboard, literal pins
    always @(negedge clk) begin
        if (chk_oe) begin
            total++;
            if (sda_oe !== exp_oe) begin
                bad++;
                $display("FAIL sda_oe at %0t: got %b want %b", $time, sda_oe, exp_oe);
            end
        end
        if (quiet) begin
            total++;
            if (sda_oe !== 1'b0) begin
                bad++;
                $display("FAIL sda_oe_quiet at %0t: got %b want 0", $time, sda_oe);
            end
        end
        if (rx_valid) begin
            total++;
            if (n_pop >= exp_rx.size()) begin
                bad++;
                $display("FAIL rx_valid_unexpected at %0t: got 1 want 0 (rx_data=%h)", $time, rx_data);
            end else begin
                if (rx_data !== exp_rx[n_pop]) begin
                    bad++;
                    $display("FAIL rx_data at %0t: got %h want %h", $time, rx_data, exp_rx[n_pop]);
                end
                n_pop++;
            end
        end
        if (tx_load) n_load++;
        if (lreq) begin
            total++;
            if (lact !== lexp) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", lname, lact, lexp);
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
        lname = n;
        lact = a;
        lexp = e;
        lreq = 1'b1;
        @(negedge clk);
        #1;
        lreq = 1'b0;
    endtask
    task automatic bit_x(input logic b, input logic eoe, output logic rd);
        sda_m = b;
        cyc(Q);
        scl_m = 1'b1;
        cyc(4);
        exp_oe = eoe;
        chk_oe = 1'b1;
        cyc(8);
        rd = sda_bus;
        chk_oe = 1'b0;
        cyc(4);
        scl_m = 1'b0;
        cyc(Q);
    endtask
    task automatic bus_start();
        if (!scl_m) begin
            sda_m = 1'b1;
            cyc(Q);
            scl_m = 1'b1;
            cyc(Q);
        end
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask
    task automatic bus_stop();
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b1;
        cyc(Q);
        sda_m = 1'b1;
        cyc(2 * Q);
    endtask
    task automatic wr_byte(input logic [7:0] b, input logic ack);
        logic rd;
        for (int i = 7; i >= 0; i--) bit_x(b[i], 1'b0, rd);
        bit_x(1'b1, ack, rd);
    endtask
    task automatic addr(input logic [7:0] a);
        m_hit = (a[7:1] == own_addr);
        wr_byte(a, m_hit);
        if (m_hit && a[0]) m_load++;
    endtask
    task automatic wdata(input logic [7:0] b);
        if (m_hit) exp_rx.push_back(b);
        wr_byte(b, m_hit);
    endtask
    task automatic rd_byte(input logic [7:0] e, input logic [7:0] nxt, input logic ack, output logic [7:0] g);
        logic rd;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, ~e[i], rd);
            g[i] = rd;
        end
        tx_data = nxt;
        bit_x(~ack, 1'b0, rd);
        if (ack) m_load++;
    endtask
    initial begin
        logic rd;
        cyc(3);
        lit("rst_sda_oe", 32'(sda_oe), 0);
        lit("rst_tx_load", 32'(tx_load), 0);
        lit("rst_rx_data", 32'(rx_data), 0);
        lit("rst_rx_valid", 32'(rx_valid), 0);
        lit("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc(5);
        bus_start();
        addr(8'h84);
        lit("t1_busy_on", 32'(busy), 1);
        wdata(8'hA5);
        bus_stop();
        lit("t1_rx_data", 32'(rx_data), 32'hA5);
        lit("t1_rx_count", 32'(n_pop), 1);
        lit("t1_busy_off", 32'(busy), 0);
        quiet = 1'b1;
        bus_start();
        addr(8'h86);
        lit("t2_busy", 32'(busy), 0);
        wdata(8'h11);
        bus_stop();
        quiet = 1'b0;
        lit("t2_busy_end", 32'(busy), 0);
        lit("t2_rx_data", 32'(rx_data), 32'hA5);
        tx_data = 8'h3C;
        bus_start();
        addr(8'h85);
        rd_byte(8'h3C, 8'hC3, 1'b1, got);
        lit("t3_byte1", 32'(got), 32'h3C);
        rd_byte(8'hC3, 8'h00, 1'b0, got);
        lit("t3_byte2", 32'(got), 32'hC3);
        lit("t3_oe_after_nack", 32'(sda_oe), 0);
        bus_stop();
        lit("t3_tx_loads", 32'(n_load), 2);
        bus_start();
        addr(8'h84);
        wdata(8'h5A);
        lit("t4_busy_wr", 32'(busy), 1);
        bus_start();
        lit("t4_busy_rs", 32'(busy), 0);
        lit("t4_rx_data", 32'(rx_data), 32'h5A);
        tx_data = 8'h96;
        addr(8'h85);
        lit("t4_busy_rd", 32'(busy), 1);
        rd_byte(8'h96, 8'h00, 1'b0, got);
        lit("t4_rd_byte", 32'(got), 32'h96);
        bus_stop();
        lit("t4_busy_stop", 32'(busy), 0);
        bus_start();
        addr(8'h84);
        bit_x(1'b1, 1'b0, rd);
        bit_x(1'b0, 1'b0, rd);
        bit_x(1'b1, 1'b0, rd);
        bit_x(1'b1, 1'b0, rd);
        bus_stop();
        lit("t5_busy", 32'(busy), 0);
        lit("t5_rx_data", 32'(rx_data), 32'h5A);
        lit("t5_rx_count", 32'(n_pop), 2);
        tx_data = 8'h00;
        bus_start();
        addr(8'h85);
        for (int i = 0; i < 4; i++) bit_x(1'b1, 1'b1, rd);
        cyc(6);
        lit("t6_oe_before_rst", 32'(sda_oe), 1);
        rst_n = 1'b0;
        #1;
        oe_now = sda_oe;
        lit("t6_oe_async", 32'(oe_now), 0);
        lit("t6_busy_rst", 32'(busy), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(5);
        rst_n = 1'b1;
        cyc(5);
        lit("t6_rx_data_rst", 32'(rx_data), 0);
        bus_start();
        addr(8'h84);
        wdata(8'h3E);
        bus_stop();
        lit("t6_rx_data", 32'(rx_data), 32'h3E);
        lit("t6_rx_count", 32'(n_pop), 3);
        lit("tx_load_total", 32'(n_load), 32'(m_load));
        cyc(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
